// File: rtl/output_grad_pkg.sv
// Shared types and constants for the output-layer gradient engine.
package output_grad_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LATCH  = 2'd1,
      ST_UPDATE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int DEF_N_HIDDEN = 4;
   localparam int DEF_W_WIDTH  = 8;
   localparam int DEF_H_WIDTH  = 10;
   localparam int DEF_Y_WIDTH  = 19;
   localparam int DEF_T_WIDTH  = 4;
   localparam int DEF_LR_SHIFT = 19;

   // Error is target - output with both zero-extended, so one extra sign bit.
   function automatic int err_width(input int y_width);
      return y_width + 1;
   endfunction

endpackage

// File: rtl/output_grad_engine_wgt_update_alu.sv
// Combinational weight update: w + ((err * h) >>> LR_SHIFT), narrowed to W_WIDTH.
// OUTPUT_GRAD_SAT_EN selects clamping (and clamp_o reporting); otherwise the sum wraps.
module wgt_update_alu #(
   parameter int W_WIDTH  = 8,
   parameter int H_WIDTH  = 10,
   parameter int E_WIDTH  = 20,
   parameter int LR_SHIFT = 19
) (
   input  logic signed [E_WIDTH-1:0] err_i,
   input  logic        [H_WIDTH-1:0] h_val_i,
   input  logic signed [W_WIDTH-1:0] w_i,
   output logic signed [W_WIDTH-1:0] w_o,
   output logic                      clamp_o
);

   localparam int P_WIDTH = E_WIDTH + H_WIDTH + 1;
   localparam int S_WIDTH = ((P_WIDTH > W_WIDTH) ? P_WIDTH : W_WIDTH) + 1;

   localparam logic signed [S_WIDTH-1:0] MAX_V =
      {{(S_WIDTH-W_WIDTH+1){1'b0}}, {(W_WIDTH-1){1'b1}}};
   localparam logic signed [S_WIDTH-1:0] MIN_V =
      {{(S_WIDTH-W_WIDTH+1){1'b1}}, {(W_WIDTH-1){1'b0}}};

   logic signed [H_WIDTH:0]   h_s;
   logic signed [P_WIDTH-1:0] prod;
   logic signed [P_WIDTH-1:0] delta;
   logic signed [S_WIDTH-1:0] sum;

   function automatic logic over_range(input logic signed [S_WIDTH-1:0] s);
      return (s > MAX_V) || (s < MIN_V);
   endfunction

   function automatic logic signed [W_WIDTH-1:0] sat_narrow(input logic signed [S_WIDTH-1:0] s);
      if (s > MAX_V)      return W_WIDTH'(MAX_V);
      else if (s < MIN_V) return W_WIDTH'(MIN_V);
      else                return W_WIDTH'(s);
   endfunction

   function automatic logic signed [W_WIDTH-1:0] wrap_narrow(input logic signed [S_WIDTH-1:0] s);
      return W_WIDTH'(s);
   endfunction

   assign h_s   = signed'({1'b0, h_val_i});
   assign prod  = P_WIDTH'(err_i) * P_WIDTH'(h_s);
   assign delta = prod >>> LR_SHIFT;
   assign sum   = S_WIDTH'(delta) + S_WIDTH'(w_i);

`ifdef OUTPUT_GRAD_SAT_EN
   assign w_o     = sat_narrow(sum);
   assign clamp_o = over_range(sum);
`else
   assign w_o     = wrap_narrow(sum);
   assign clamp_o = 1'b0;
`endif

endmodule

// File: rtl/output_grad_engine.sv
// Output-layer backprop engine: one pass updates N_HIDDEN weights, one per cycle.
// Build option OUTPUT_GRAD_SAT_EN: saturate weights instead of wrapping.
module output_grad_engine
   import output_grad_pkg::*;
#(
   parameter int N_HIDDEN = DEF_N_HIDDEN,
   parameter int W_WIDTH  = DEF_W_WIDTH,
   parameter int H_WIDTH  = DEF_H_WIDTH,
   parameter int Y_WIDTH  = DEF_Y_WIDTH,
   parameter int T_WIDTH  = DEF_T_WIDTH,
   parameter int LR_SHIFT = DEF_LR_SHIFT
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        start_i,
   input  logic                        clear_i,
   input  logic        [T_WIDTH-1:0]   target_i,
   input  logic        [Y_WIDTH-1:0]   final_i,
   output logic [$clog2(N_HIDDEN)-1:0] h_addr_o,
   input  logic        [H_WIDTH-1:0]   h_val_i,
   input  logic [$clog2(N_HIDDEN)-1:0] w_rd_addr_i,
   output logic signed [W_WIDTH-1:0]   w_rd_data_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        sat_o
);

   localparam int AW = $clog2(N_HIDDEN);
   localparam int EW = err_width(Y_WIDTH);

   state_t                    state_q, state_d;
   logic [AW-1:0]             k_q;
   logic signed [EW-1:0]      err_q;
   logic [T_WIDTH-1:0]        tgt_q;
   logic [Y_WIDTH-1:0]        fin_q;
   logic signed [W_WIDTH-1:0] w_q [N_HIDDEN];
   logic signed [W_WIDTH-1:0] w_new;
   logic                      clamp;
   logic                      wr_en;
   logic                      start_acc;
   logic                      sat_q;
   logic                      k_last;

   assign k_last    = (k_q == AW'(N_HIDDEN-1));
   assign start_acc = (state_q == ST_IDLE) && start_i && !clear_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      busy_o   = 1'b0;
      done_o   = 1'b0;
      h_addr_o = '0;
      wr_en    = 1'b0;
      case (state_q)
         ST_IDLE:   if (start_i) state_d = ST_LATCH;
         ST_LATCH: begin
            busy_o  = 1'b1;
            state_d = ST_UPDATE;
         end
         ST_UPDATE: begin
            busy_o   = 1'b1;
            h_addr_o = k_q;
            wr_en    = 1'b1;
            if (k_last) state_d = ST_DONE;
         end
         ST_DONE: begin
            busy_o  = 1'b1;
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default:   state_d = ST_IDLE;
      endcase
      // Clear aborts any pass silently: no write, no completion pulse.
      if (clear_i) begin
         state_d = ST_IDLE;
         done_o  = 1'b0;
         wr_en   = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (start_acc) begin
         tgt_q <= target_i;
         fin_q <= final_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         k_q   <= '0;
         err_q <= '0;
         sat_q <= 1'b0;
      end else if (clear_i) begin
         k_q   <= '0;
         sat_q <= 1'b0;
      end else begin
         if (start_acc)           sat_q <= 1'b0;
         else if (wr_en && clamp) sat_q <= 1'b1;
         if (state_q == ST_LATCH)
            err_q <= signed'(EW'(tgt_q)) - signed'(EW'(fin_q));
         if (wr_en) k_q <= k_last ? '0 : k_q + AW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < N_HIDDEN; i++) w_q[i] <= '0;
      end else if (clear_i) begin
         for (int i = 0; i < N_HIDDEN; i++) w_q[i] <= '0;
      end else if (wr_en) begin
         w_q[k_q] <= w_new;
      end
   end

   wgt_update_alu #(
      .W_WIDTH  (W_WIDTH),
      .H_WIDTH  (H_WIDTH),
      .E_WIDTH  (EW),
      .LR_SHIFT (LR_SHIFT)
   ) u_alu (
      .err_i   (err_q),
      .h_val_i (h_val_i),
      .w_i     (w_q[k_q]),
      .w_o     (w_new),
      .clamp_o (clamp)
   );

   // Indices beyond N_HIDDEN exist only when N_HIDDEN is not a power of two.
   generate
      if ((1 << AW) == N_HIDDEN) begin : g_rd_full
         assign w_rd_data_o = w_q[w_rd_addr_i];
      end else begin : g_rd_guard
         assign w_rd_data_o = (w_rd_addr_i <= AW'(N_HIDDEN-1)) ? w_q[w_rd_addr_i] : '0;
      end
   endgenerate

   assign sat_o = sat_q;

endmodule

// File: doc/output_grad_engine.md
OUTPUT_GRAD_ENGINE -- requirements
Module: output_grad_engine

Interface
REQ-001 Parameter N_HIDDEN, default 4: number of hidden-to-output weights updated per pass (>=2).
REQ-002 Parameter W_WIDTH, default 8: signed two's-complement weight width.
REQ-003 Parameter H_WIDTH, default 10: unsigned hidden activation width.
REQ-004 Parameter Y_WIDTH, default 19: unsigned network output width.
REQ-005 Parameter T_WIDTH, default 4: unsigned target width (T_WIDTH <= Y_WIDTH).
REQ-006 Parameter LR_SHIFT, default 19: arithmetic right-shift applied to the error-activation product (learning rate).
REQ-007 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-008 rst_i  in  1  reset, asynchronous, active-low.
REQ-009 start_i  in  1  request one backprop pass; sampled only in IDLE.
REQ-010 clear_i  in  1  synchronous weight zeroing and abort.
REQ-011 target_i  in  T_WIDTH  training target, sampled with accepted start_i.
REQ-012 final_i  in  Y_WIDTH  network output, sampled with accepted start_i.
REQ-013 h_addr_o  out  clog2(N_HIDDEN)  hidden-value index being read.
REQ-014 h_val_i  in  H_WIDTH  hidden value at h_addr_o, valid same cycle.
REQ-015 w_rd_addr_i  in  clog2(N_HIDDEN)  forward-pass weight read index.
REQ-016 w_rd_data_o  out  W_WIDTH  stored weight at w_rd_addr_i, combinational.
REQ-017 busy_o  out  1  high from the cycle after start is accepted until the DONE cycle, inclusive.
REQ-018 done_o  out  1  one-cycle pulse at pass completion.
REQ-019 sat_o  out  1  sticky flag: some weight clamped during the current/last pass.

Function
REQ-020 FSM states IDLE, LATCH, UPDATE, DONE; IDLE->LATCH on start_i, LATCH->UPDATE, UPDATE->DONE after index N_HIDDEN-1, DONE->IDLE unconditionally.
REQ-021 In LATCH, err = target_i - final_i (both zero-extended, signed, Y_WIDTH+1 bits) is registered from values captured at start acceptance.
REQ-022 In UPDATE, index k runs 0..N_HIDDEN-1, one weight per cycle; h_addr_o = k; h_addr_o = 0 in all other states.
REQ-023 Per weight: prod = err * h_val_i (signed, full width), delta = prod >>> LR_SHIFT, w[k] <= w[k] + delta, result narrowed to W_WIDTH per REQ-033/034.
REQ-024 Latency: start accepted at edge 0 -> done_o high during cycle N_HIDDEN+2; next start accepted no earlier than the cycle after DONE.
REQ-025 start_i outside IDLE is ignored; not queued.
REQ-026 err == 0: pass still runs full length; weights unchanged; done_o pulses.
REQ-027 w_rd_data_o during UPDATE returns pre-update value for index k until the writing edge.
REQ-028 sat_o clears on start acceptance; sets on any clamp; holds until next accepted start.
REQ-029 clear_i (priority over all): all weights <= 0, FSM -> IDLE, k <= 0, sat_o <= 0, no done_o pulse; asserted mid-pass aborts it.

Reset
REQ-030 rst_i low: asynchronously FSM = IDLE, all weights = 0, err = 0, k = 0.
REQ-031 Outputs during/after reset: busy_o = 0, done_o = 0, sat_o = 0, h_addr_o = 0, w_rd_data_o = 0.
REQ-032 Reset deasserting mid-pass context: block restarts in IDLE; no partial pass resumes.

Configuration
REQ-033 Macro OUTPUT_GRAD_SAT_EN defined: sum clamped to [-2^(W_WIDTH-1), 2^(W_WIDTH-1)-1], clamp sets sat_o.
REQ-034 Macro undefined: sum truncated to low W_WIDTH bits (wrap-around); sat_o tied 0.

Structure
REQ-035 Package output_grad_pkg holds the FSM state enum, default parameter constants and the err width function.
REQ-036 Sub-module wgt_update_alu: combinational prod/shift/add/narrow, one instance; FSM, counter and weight array stay in output_grad_engine.

Verification
REQ-038 Reset then read all indices -> w_rd_data_o = 0, busy_o = 0, done_o = 0.
REQ-039 Defaults, target 9, final 1, h all 512, start -> err 8, delta = (8*512)>>>19 = 0, weights stay 0; done_o in cycle 6.
REQ-040 LR_SHIFT=8, target 15, final 0, h = {256,512,0,1023}, weights 0 -> weights {15,30,0,59}.
REQ-041 Same as REQ-040 with h=1023, 3 passes: with OUTPUT_GRAD_SAT_EN weight 127 and sat_o=1; without, weight wraps to -79, sat_o=0.
REQ-042 clear_i asserted during UPDATE at k=2 -> all weights 0, IDLE next cycle, no done_o; start_i during busy ignored.
